// File: rtl/pixel_frame_capture_pkg.sv
// Shared image-size constants, capture FSM encoding and frame-size helper
// used by both the pixel source and this frame-capture sink.
package pixel_frame_capture_pkg;

    localparam int IMG_W_DEF    = 256;
    localparam int IMG_H_DEF    = 128;
    localparam int CHANNELS_DEF = 3;
    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    function automatic int frame_total(input int w, input int h, input int c);
        return w * h * c;
    endfunction

endpackage

// File: rtl/pixel_frame_capture_skid_fifo2.sv
// Two-entry FIFO decoupling the upstream byte handshake from the frame
// buffer write port; head is the oldest stored byte.
module pixel_frame_capture_skid_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/pixel_frame_capture.sv
// Frame capture sink: accepts processed bytes over valid/ready, buffers them
// in a 2-entry FIFO and writes one full frame sequentially into a frame buffer.
module pixel_frame_capture
    import pixel_frame_capture_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wready,
    output logic          busy,
    output logic          frame_done,
    output logic [AW-1:0] byte_count
);

    localparam int            TOTAL     = frame_total(IMG_W, IMG_H, CHANNELS);
    localparam int            CW        = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
    localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);

    cap_state_t    state;
    cap_state_t    state_next;
    logic [DW-1:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_count;
    logic [1:0]    count_next;
    logic          push;
    logic          pop;
    logic [CW-1:0] accept_count;
    logic [CW-1:0] accept_next;

    pixel_frame_capture_skid_fifo2 #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pix_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // accept_count caps intake at one frame so the last-cycle slot of
    // CAPTURE can never swallow a byte belonging to the next frame
    always_comb begin
        push        = pix_valid && pix_ready && !fifo_full;
        pop         = mem_we && mem_wready && !fifo_empty;
        count_next  = fifo_count + 2'(push) - 2'(pop);
        accept_next = (state == ST_IDLE) ? '0 : accept_count + CW'(push);
        state_next  = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_CAPTURE;
            ST_CAPTURE: if (pop && (byte_count == LAST_ADDR)) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            accept_count <= '0;
            pix_ready    <= 1'b0;
            mem_we       <= 1'b0;
            byte_count   <= '0;
        end else begin
            state        <= state_next;
            accept_count <= accept_next;
            pix_ready    <= (state_next == ST_CAPTURE) && (count_next != 2'd2)
                            && (accept_next != TOTAL_CNT);
            mem_we       <= (state_next == ST_CAPTURE) && (count_next != 2'd0);
            if ((state == ST_IDLE) && start) begin
                byte_count <= '0;
            end else if (pop) begin
                byte_count <= byte_count + AW'(1);
            end
        end
    end

    assign mem_addr   = byte_count;
    assign mem_wdata  = fifo_head;
    assign busy       = (state == ST_CAPTURE);
    assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture using a reduced 8x4x3 frame so that
// several complete frames fit in a short run.
module tb_pixel_frame_capture;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 4;
    localparam int CHANNELS = 3;
    localparam int DW       = 8;
    localparam int AW       = 7;
    localparam int TOTAL    = IMG_W * IMG_H * CHANNELS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] byte_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int wr_expect_addr = 0;
    int last_wr_cyc = -1;
    int done_cyc = -1;
    logic [7:0] base = 8'h00;
    logic [7:0] exp_byte;

    pixel_frame_capture #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CHANNELS(CHANNELS), .DW(DW), .AW(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .busy       (busy),
        .frame_done (frame_done),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every completed write must land on the next address
    // with the byte the source sent for that position.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid && pix_ready) acc_cnt++;
            if (mem_we && mem_wready) begin
                exp_byte = base + wr_expect_addr[7:0];
                checkOutput("wr_addr", 32'(mem_addr), wr_expect_addr);
                checkOutput("wr_data", 32'(mem_wdata), 32'(exp_byte));
                if (wr_expect_addr == TOTAL - 1) last_wr_cyc = cyc;
                wr_cnt++;
                wr_expect_addr++;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic wr,
                                 input logic st, input int n);
        pix_valid  = v;
        pix_data   = d;
        mem_wready = wr;
        start      = st;
        repeat (n) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(pix_ready), 0);
        checkOutput({tag, "_we"}, 32'(mem_we), 0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "_wdata"}, 32'(mem_wdata), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(frame_done), 0);
        checkOutput({tag, "_count"}, 32'(byte_count), 0);
    endtask

    task automatic runFrame(input logic [7:0] fbase, input int offer, input int stall_at,
                            input int stall_len, input int restart_at, input int reset_at,
                            input bit start_on_done, input int expect_span);
        int  src_idx;
        int  stall_left;
        int  budget;
        int  post;
        int  start_cyc;
        bit  done_seen;
        bit  took;
        bit  restarted;
        src_idx    = 0;
        stall_left = stall_len;
        budget     = 0;
        post       = 0;
        done_seen  = 0;
        restarted  = 0;
        base           = fbase;
        wr_expect_addr = 0;
        acc_cnt        = 0;
        wr_cnt         = 0;
        done_cnt       = 0;
        last_wr_cyc    = -1;
        done_cyc       = -1;

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1);
        start_cyc = cyc;
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_ready", 32'(pix_ready), 1);
        checkOutput("start_count", 32'(byte_count), 0);

        while (budget < 2000 && (!done_seen || post < 8)) begin
            budget++;
            if (done_seen) post++;
            if (frame_done && !done_seen) begin
                done_seen = 1;
                checkOutput("done_ready", 32'(pix_ready), 0);
                checkOutput("done_busy", 32'(busy), 0);
                checkOutput("done_count", 32'(byte_count), TOTAL);
            end
            pix_valid  = (src_idx < offer);
            pix_data   = fbase + src_idx[7:0];
            mem_wready = 1'b1;
            start      = 1'b0;
            if (restart_at >= 0 && src_idx == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1;
            end
            if (start_on_done && frame_done) start = 1'b1;
            if (stall_left > 0 && wr_expect_addr == stall_at) begin
                mem_wready = 1'b0;
                stall_left--;
                if (stall_left == 0) begin
                    checkOutput("stall_ready", 32'(pix_ready), 0);
                    checkOutput("stall_we", 32'(mem_we), 1);
                    checkOutput("stall_addr", 32'(mem_addr), stall_at);
                    checkOutput("stall_buffered", acc_cnt - wr_cnt, 2);
                end
                if (reset_at >= 0 && wr_expect_addr == reset_at && stall_left <= stall_len - 3) begin
                    checkOutput("pre_rst_ready", 32'(pix_ready), 0);
                    #2 rst = 1'b1;
                    #1;
                    checkResetValues("async_rst");
                    @(posedge clk);
                    #1;
                    rst       = 1'b0;
                    pix_valid = 1'b0;
                    checkOutput("rst_no_done", done_cnt, 0);
                    checkOutput("rst_idle_busy", 32'(busy), 0);
                    return;
                end
            end
            @(negedge clk);
            took = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (took) begin
                src_idx++;
                if (src_idx == 1) begin
                    checkOutput("first_we", 32'(mem_we), 1);
                    checkOutput("first_addr", 32'(mem_addr), 0);
                    checkOutput("first_data", 32'(mem_wdata), 32'(fbase));
                end
            end
        end
        start = 1'b0;
        checkOutput("frame_timeout", 32'(done_seen), 1);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("writes", wr_cnt, TOTAL);
        checkOutput("accepts", acc_cnt, TOTAL);
        checkOutput("done_latency", done_cyc - last_wr_cyc, 1);
        checkOutput("end_count", 32'(byte_count), TOTAL);
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_ready", 32'(pix_ready), 0);
        if (expect_span >= 0) checkOutput("frame_span", done_cyc - start_cyc, expect_span);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 8'h00;
        mem_wready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        $display("[TB] idle offer without start");
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 6);
        checkOutput("idle_ready", 32'(pix_ready), 0);
        checkOutput("idle_accepts", acc_cnt, 0);
        checkOutput("idle_writes", wr_cnt, 0);
        checkOutput("idle_count", 32'(byte_count), 0);
        checkOutput("idle_busy", 32'(busy), 0);

        $display("[TB] frame A continuous stream");
        runFrame(8'h00, TOTAL, -1, 0, -1, -1, 1'b0, TOTAL + 1);

        $display("[TB] frame B stall, overrun offer, start on done");
        runFrame(8'h40, TOTAL + 6, 50, 10, -1, -1, 1'b1, -1);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 5);
        checkOutput("post_accepts", acc_cnt, TOTAL);
        checkOutput("post_writes", wr_cnt, TOTAL);
        checkOutput("post_ready", 32'(pix_ready), 0);
        checkOutput("post_we", 32'(mem_we), 0);
        checkOutput("post_count", 32'(byte_count), TOTAL);

        $display("[TB] frame C reset under back-pressure");
        runFrame(8'h80, TOTAL + 6, 60, 10, -1, 60, 1'b0, -1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 3);
        checkOutput("after_rst_done", done_cnt, 0);

        $display("[TB] frame D second start mid-frame");
        runFrame(8'hC0, TOTAL, -1, 0, 20, -1, 1'b0, TOTAL + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
